// File: rtl/decoder_fec.sv
// Hamming(7,4) receive decoder: pairs of encoded FIFO words -> one corrected 32-bit message word.
// Optional statistics counters are built only when FEC_ERR_STATS_EN is defined.
module decoder_fec #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  full,
    output logic                  busy,
    input  logic                  stat_clr,
    output logic [CNT_WIDTH-1:0]  corr_cnt,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int unsigned NUM_CW = 4;
    localparam int unsigned CW_W   = 7;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned HALF_W = NUM_CW * NIB_W;
    localparam int unsigned PAD_LO = NUM_CW * CW_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_half;
    logic [HALF_W-1:0]     r_low;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [HALF_W-1:0]     w_dec_half;
    logic [NUM_CW-1:0]     w_corr_flag;

    // Returns {corrected, nibble} for one codeword; bit i-1 holds Hamming position i.
    function automatic logic [NIB_W:0] decode_cw(input logic [CW_W-1:0] cw_in);
        logic [CW_W-1:0] cw;
        logic [2:0]      syn;
        cw     = cw_in;
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        if (syn != 3'd0) begin
            cw = cw ^ (CW_W'(1) << (syn - 3'd1));
        end
        return {(syn != 3'd0), cw[6], cw[5], cw[4], cw[2]};
    endfunction

    always_comb begin
        w_dec_half  = '0;
        w_corr_flag = '0;
        for (int k = 0; k < NUM_CW; k++) begin
            logic [NIB_W:0] res;
            res = decode_cw(rd_data[CW_W*k +: CW_W]);
            w_corr_flag[k]                = res[NIB_W];
            w_dec_half[NIB_W*k +: NIB_W]  = res[NIB_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rd_en/wr_en decode straight from the state so the strobes match the FIFO handshakes.
    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && !empty) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_en       = 1'b1;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = r_half ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                if (!full) begin
                    wr_en       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Half-word pairing; a held low half survives enable dropping but not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_half    <= 1'b0;
            r_low     <= '0;
            r_wr_data <= '0;
        end else if (r_state == S_CAPTURE) begin
            if (r_half) begin
                r_wr_data <= {w_dec_half, r_low};
                r_half    <= 1'b0;
            end else begin
                r_low  <= w_dec_half;
                r_half <= 1'b1;
            end
        end
    end

    assign wr_data = r_wr_data;
    assign busy    = (r_state != S_IDLE) || r_half;

`ifdef FEC_ERR_STATS_EN
    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    logic [CNT_WIDTH-1:0] r_corr_cnt;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [2:0]           w_corr_num;
    logic [SUM_W-1:0]     w_corr_sum;
    logic                 w_unused;

    always_comb begin
        w_corr_num = '0;
        for (int k = 0; k < NUM_CW; k++) begin
            w_corr_num = w_corr_num + 3'(w_corr_flag[k]);
        end
    end

    assign w_corr_sum = {1'b0, r_corr_cnt} + SUM_W'(w_corr_num);

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_corr_cnt <= '0;
            r_word_cnt <= '0;
        end else begin
            if (r_state == S_CAPTURE) begin
                r_corr_cnt <= w_corr_sum[CNT_WIDTH] ? '1 : w_corr_sum[CNT_WIDTH-1:0];
            end
            if (wr_en && (r_word_cnt != '1)) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign corr_cnt = r_corr_cnt;
    assign word_cnt = r_word_cnt;
    assign w_unused = ^rd_data[DATA_WIDTH-1:PAD_LO];
`else
    logic w_unused;

    assign corr_cnt = '0;
    assign word_cnt = '0;
    assign w_unused = ^{stat_clr, w_corr_flag, rd_data[DATA_WIDTH-1:PAD_LO]};
`endif

endmodule
